// File: rtl/t_word_server_pkg.sv
// ---------------------------------------------------------------------------
// t_word_server_pkg
// Shared constants, state encoding and the word-count helper used by the
// T-sequence word server and its word store.
// ---------------------------------------------------------------------------
package t_word_server_pkg;

   localparam int SRAM_WORD         = 64;   // bits per stored word
   localparam int MAX_WORDS         = 256;  // depth of the word store
   localparam int PTR_W             = 8;    // log2(MAX_WORDS)
   localparam int T_SIZE_W          = 12;   // width of the T length in elements
   localparam int ELEM_PER_WORD_LOG = 2;    // log2(T elements per word)

   // Pointers and counters carry one extra bit so they can hold MAX_WORDS itself.
   typedef logic [PTR_W:0] cnt_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      READY = 2'd2,
      SERVE = 2'd3
   } state_t;

   typedef struct packed {
      cnt_t nw;       // word count, always within 1..MAX_WORDS
      logic clamped;  // raw count fell outside 1..MAX_WORDS
   } nw_t;

   localparam int WORDS_W = T_SIZE_W - ELEM_PER_WORD_LOG + 1;
   localparam logic [T_SIZE_W:0] ROUND_UP  = (T_SIZE_W+1)'((1 << ELEM_PER_WORD_LOG) - 1);
   localparam logic [WORDS_W-1:0] MAX_RAW  = WORDS_W'(MAX_WORDS);

   // ceil(t_size / 2^ELEM_PER_WORD_LOG), clamped into 1..MAX_WORDS.
   function automatic nw_t calc_nw(input logic [T_SIZE_W-1:0] t_size);
      logic [T_SIZE_W:0]  sum;
      logic [WORDS_W-1:0] words;
      nw_t                r;
      sum   = {1'b0, t_size} + ROUND_UP;
      words = sum[T_SIZE_W:ELEM_PER_WORD_LOG];
      if (words == '0) begin
         r.nw      = cnt_t'(1);
         r.clamped = 1'b1;
      end else if (words > MAX_RAW) begin
         r.nw      = cnt_t'(MAX_WORDS);
         r.clamped = 1'b1;
      end else begin
         r.nw      = words[PTR_W:0];
         r.clamped = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/t_word_store.sv
// ---------------------------------------------------------------------------
// t_word_store
// 1R1W synchronous word memory, one-cycle read latency. A read and write to
// the same address in the same cycle returns the word being written.
// Ports:
//   clk, rst_n         clock, async active-low reset (read register only)
//   wr_en/addr/data    write port
//   rd_en/addr         read port request
//   rd_data            registered read data, holds between reads
// ---------------------------------------------------------------------------
module t_word_store
   import t_word_server_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 wr_en,
   input  logic [PTR_W-1:0]     wr_addr,
   input  logic [SRAM_WORD-1:0] wr_data,
   input  logic                 rd_en,
   input  logic [PTR_W-1:0]     rd_addr,
   output logic [SRAM_WORD-1:0] rd_data
);

   logic [SRAM_WORD-1:0] mem [MAX_WORDS];

   // NOTE: the array has no reset so it can map onto an SRAM macro; contents
   // are only meaningful after the host has loaded them.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments for all clocked state, so every
      // register samples values from before the edge.
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
      end
   end

endmodule

// File: rtl/t_word_server.sv
// ---------------------------------------------------------------------------
// t_word_server
// Holds the T sequence in a word store loaded once by the host, then serves
// it word by word to the data processor and stores each word sent back.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   i_load_valid/o_load_ready    host load handshake
//   i_load_data/last/tsize       load word, final beat, T length (on last)
//   i_start_calc, i_finish       enter / leave serving (pulses)
//   o_T_size                     registered T length
//   i_sram_request               request next word
//   o_request_data/valid         served word, one cycle after the request
//   i_sram_send, i_send_data     write-back word
//   o_pass_done                  pulse after the last word of a pass returns
//   o_hazard                     sticky protocol / size error
//   o_busy                       high while loading or serving
// ---------------------------------------------------------------------------
module t_word_server
   import t_word_server_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_load_valid,
   output logic                 o_load_ready,
   input  logic [SRAM_WORD-1:0] i_load_data,
   input  logic                 i_load_last,
   input  logic [T_SIZE_W-1:0]  i_load_tsize,
   input  logic                 i_start_calc,
   input  logic                 i_finish,
   output logic [T_SIZE_W-1:0]  o_T_size,
   input  logic                 i_sram_request,
   output logic [SRAM_WORD-1:0] o_request_data,
   output logic                 o_request_valid,
   input  logic                 i_sram_send,
   input  logic [SRAM_WORD-1:0] i_send_data,
   output logic                 o_pass_done,
   output logic                 o_hazard,
   output logic                 o_busy
);

   state_t              state_q, state_d;
   cnt_t                wp_q, wp_d;
   cnt_t                rp_q, rp_d;
   cnt_t                out_q, out_d;    // requests minus sends
   cnt_t                nw_q, nw_d;
   logic [T_SIZE_W-1:0] tsize_q, tsize_d;
   logic                hazard_q, hazard_d;
   logic                pass_done_q, pass_done_d;
   logic                req_valid_q, req_valid_d;

   logic                 wr_en;
   logic [PTR_W-1:0]     wr_addr;
   logic [SRAM_WORD-1:0] wr_data;
   logic                 rd_en;
   logic [PTR_W-1:0]     rd_addr;
   nw_t                  nw_calc;
   cnt_t                 last_idx;

   t_word_store u_store (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (o_request_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         wp_q        <= '0;
         rp_q        <= '0;
         out_q       <= '0;
         nw_q        <= '0;
         tsize_q     <= '0;
         hazard_q    <= 1'b0;
         pass_done_q <= 1'b0;
         req_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wp_q        <= wp_d;
         rp_q        <= rp_d;
         out_q       <= out_d;
         nw_q        <= nw_d;
         tsize_q     <= tsize_d;
         hazard_q    <= hazard_d;
         pass_done_q <= pass_done_d;
         req_valid_q <= req_valid_d;
      end
   end

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path
      // through the case can leave one unassigned and infer a latch.
      state_d     = state_q;
      wp_d        = wp_q;
      rp_d        = rp_q;
      out_d       = out_q;
      nw_d        = nw_q;
      tsize_d     = tsize_q;
      hazard_d    = hazard_q;
      pass_done_d = 1'b0;
      req_valid_d = 1'b0;
      wr_en       = 1'b0;
      wr_addr     = wp_q[PTR_W-1:0];
      wr_data     = i_load_data;
      rd_en       = 1'b0;
      rd_addr     = rp_q[PTR_W-1:0];
      nw_calc     = calc_nw(i_load_tsize);
      last_idx    = nw_q - cnt_t'(1);

      unique case (state_q)
         // IDLE always has wp==0, so its first beat behaves like a LOAD beat.
         IDLE, LOAD: begin
            if (i_load_valid) begin
               state_d = LOAD;
               if (wp_q == cnt_t'(MAX_WORDS)) begin
                  hazard_d = 1'b1;      // store full: beat dropped
               end else begin
                  wr_en = 1'b1;
                  wp_d  = wp_q + cnt_t'(1);
               end
               if (i_load_last) begin
                  tsize_d = i_load_tsize;
                  nw_d    = nw_calc.nw;
                  if (nw_calc.clamped) hazard_d = 1'b1;
                  state_d = READY;
               end
            end
         end

         READY: begin
            if (i_finish) begin
               state_d  = IDLE;
               wp_d     = '0;
               rp_d     = '0;
               out_d    = '0;
               hazard_d = 1'b0;
            end else if (i_start_calc) begin
               state_d = SERVE;
               wp_d    = '0;
               rp_d    = '0;
               out_d   = '0;
            end
         end

         SERVE: begin
            if (i_sram_request) begin
               rd_en       = 1'b1;
               req_valid_d = 1'b1;
               rp_d        = (rp_q == last_idx) ? '0 : rp_q + cnt_t'(1);
            end
            if (i_sram_send) begin
               wr_en   = 1'b1;
               wr_data = i_send_data;
               if (wp_q == last_idx) begin
                  wp_d        = '0;
                  pass_done_d = 1'b1;
               end else begin
                  wp_d = wp_q + cnt_t'(1);
               end
            end
            // Simultaneous request and send leave the count untouched.
            unique case ({i_sram_request, i_sram_send})
               2'b10: begin
                  if (out_q == nw_q) hazard_d = 1'b1;
                  else               out_d    = out_q + cnt_t'(1);
               end
               2'b01: begin
                  if (out_q == '0) hazard_d = 1'b1;
                  else             out_d    = out_q - cnt_t'(1);
               end
               default: ;
            endcase
            // The final cycle's read still completes; only pointers clear.
            if (i_finish) begin
               state_d  = IDLE;
               wp_d     = '0;
               rp_d     = '0;
               out_d    = '0;
               hazard_d = 1'b0;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign o_load_ready    = (state_q == IDLE) || (state_q == LOAD);
   assign o_busy          = (state_q == LOAD) || (state_q == SERVE);
   assign o_T_size        = tsize_q;
   assign o_request_valid = req_valid_q;
   assign o_pass_done     = pass_done_q;
   assign o_hazard        = hazard_q;

endmodule
